rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (RFWe/A3/RF_WD/WPC) between the in-order
//  pipeline WB stage and the long-latency multiply/divide unit (MDU), which writes GPRs directly.
//  Holds one MDU result in a skid buffer until the port is free.
//  Keeps a pending-destination scoreboard that stalls ID on RAW/WAW hazards.
//  Sits between the WB stage, the MDU, the ID hazard logic and the register file.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive cycles a buffered MDU result may lose to WB before wb_hold asserts
//  CNT_W         3   width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   synchronous, active-low (state cleared at posedge clk when reset==0)
//  wb_we        in   1   WB stage write request
//  wb_a3        in   5   WB destination register
//  wb_wd        in   32  WB write data
//  wb_pc        in   32  PC of the WB instruction (trace only)
//  wb_hold      out  1   freeze the WB stage; its request must be re-presented unchanged next cycle
//  md_valid     in   1   MDU result valid
//  md_ready     out  1   arbiter can accept an MDU result this cycle
//  md_a3        in   5   MDU destination register
//  md_wd        in   32  MDU result data
//  md_pc        in   32  PC of the issuing MDU instruction
//  md_issue     in   1   an MDU op leaves ID this cycle; mark md_issue_a3 pending
//  md_issue_a3  in   5   destination register of the issued MDU op
//  id_a1        in   5   ID rs, checked against the scoreboard
//  id_a2        in   5   ID rt, checked against the scoreboard
//  id_a3        in   5   ID destination, WAW check
//  id_stall     out  1   ID must stall (hazard against a pending MDU destination)
//  RFWe         out  1   register-file write enable
//  A3           out  5   register-file write address
//  RF_WD        out  32  register-file write data
//  WPC          out  32  register-file trace PC
// BEHAVIOUR
//  Definitions
//  - A WB request counts only when wb_we==1 && wb_a3!=0.
//  - Skid buffer state: buf_v, buf_a3, buf_wd, buf_pc.
//  - Handshake: md_ready = ~buf_v. Accept = md_valid && md_ready. An accepted result is
//    registered into the buffer at the next posedge, so the earliest commit is the cycle after accept.
//  Port grant (combinational, 0-cycle pass-through for WB)
//  - Grant MD if buf_v && (no WB request || hold_q). Otherwise WB drives the port.
//  - MD grant: RFWe=1, A3/RF_WD/WPC come from the buffer; buf_v clears at the next posedge.
//  - WB grant: RFWe equals the WB request; A3/RF_WD/WPC are the wb_* inputs.
//  - Idle port: A3=0, RF_WD=0, WPC=0.
//  - A WB request that loses to a held MD commit is not lost: WB is frozen by wb_hold.
//  Starvation counter wait_cnt
//  - Increments each cycle buf_v is set and WB wins.
//  - Clears on MD grant or when buf_v==0.
//  - hold_q is registered: it sets when wait_cnt==STARVE_LIMIT-1 and WB wins, and clears on MD grant.
//  - wb_hold = hold_q. Max MD wait = STARVE_LIMIT+1 cycles.
//  Scoreboard pend[31:1] (pend[0] is constant 0)
//  - On md_issue with md_issue_a3!=0: pend[md_issue_a3] sets.
//  - On MD grant: pend[buf_a3] clears.
//  - Set and clear of the same index in the same cycle: set wins.
//  - id_stall = pend[id_a1] | pend[id_a2] | pend[id_a3], evaluated combinationally.
//  - Register 0 never stalls.
//  - Because of the WAW stall, WB and MD never target the same nonzero register concurrently.
//  Reset (reset==0 at posedge)
//  - Clears buf_v, pend, wait_cnt and hold_q, including mid-operation; buffered results are discarded.
//  - Outputs after reset: md_ready=1, wb_hold=0, id_stall=0, RFWe=WB request, A3/RF_WD/WPC per grant.
//  - md_valid during reset is ignored.
// STRUCTURE
//  - Shared package mips_defs: REG_W=5, DATA_W=32, REG_ZERO=5'd0.
//  - Sub-module rf_scoreboard: pend vector, set/clear ports, three lookup ports.
//  - Arbiter, skid buffer and starvation counter are implemented in the top level.
// TESTING
//  1 WB only: wb_we=1, wb_a3=8, wb_wd=0x1234 -> same cycle RFWe=1, A3=8, RF_WD=0x1234.
//    wb_a3=0 -> RFWe=0.
//  2 MD on an idle port: md_valid=1, md_a3=9, md_wd=0xCAFE -> md_ready falls next cycle;
//    that cycle RFWe=1, A3=9; md_ready=1 the following cycle.
//  3 Starvation: buffered MD result plus wb_we=1 every cycle -> MD loses 4 cycles, wb_hold=1 on cycle 5;
//    MD commits on cycle 5; the frozen WB write commits on cycle 6.
//  4 Scoreboard: md_issue with a3=10, then id_a1=10 -> id_stall=1 until the cycle after the MD commit to 10.
//    id_a2=0 -> never stalls.
//  5 Set/clear collision: MD commit to 10 and md_issue_a3=10 in the same cycle -> pend[10] remains 1.
//  6 Reset mid-operation: reset=0 while buf_v=1 and hold_q=1 -> next cycle md_ready=1, wb_hold=0,
//    id_stall=0, and no write from the discarded buffer.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file types for the WB/MDU write-port arbiter.
// Defines register/data widths, the skid-buffer record and the port-grant encoding.
package mips_defs;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic     v;
    reg_idx_t a3;
    word_t    wd;
    word_t    pc;
  } md_buf_t;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_MD   = 2'd2
  } grant_e;

  // Writes to r0 are architecturally discarded, so they never count as requests.
  function automatic logic is_write(input logic we, input reg_idx_t a3);
    return we && (a3 != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard for in-flight MDU results.
// One bit per GPR; bit 0 is held at zero so r0 never reports a hazard.
module rf_scoreboard
  import mips_defs::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t lu_a1,
  input  reg_idx_t lu_a2,
  input  reg_idx_t lu_a3,
  output logic     hit_a1,
  output logic     hit_a2,
  output logic     hit_a3
);

  logic [2**REG_W-1:0] pend_q;
  logic [2**REG_W-1:0] pend_d;

  // Set is applied after clear so a same-cycle reissue to the retiring register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_idx] = 1'b0;
    if (set_en) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign hit_a1 = pend_q[lu_a1];
  assign hit_a2 = pend_q[lu_a2];
  assign hit_a3 = pend_q[lu_a3];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU.
// WB passes straight through; one MDU result waits in a skid buffer, with starvation relief via wb_hold.
module rf_wb_arbiter
  import mips_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_a3,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_pc,
  output logic              wb_hold,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_W-1:0]  md_a3,
  input  logic [DATA_W-1:0] md_wd,
  input  logic [DATA_W-1:0] md_pc,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_issue_a3,
  input  logic [REG_W-1:0]  id_a1,
  input  logic [REG_W-1:0]  id_a2,
  input  logic [REG_W-1:0]  id_a3,
  output logic              id_stall,
  output logic              RFWe,
  output logic [REG_W-1:0]  A3,
  output logic [DATA_W-1:0] RF_WD,
  output logic [DATA_W-1:0] WPC
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(STARVE_LIMIT - 1);

  md_buf_t          buf_q, buf_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             hold_q, hold_d;

  logic   wb_req;
  logic   md_grant;
  logic   wb_wins;
  grant_e grant;
  logic   hit_a1, hit_a2, hit_a3;

  assign md_ready = ~buf_q.v;
  assign wb_hold  = hold_q;

  // Port grant and next-state logic; WB owns the port unless the buffer is free to go or has starved.
  always_comb begin
    wb_req   = is_write(wb_we, wb_a3);
    md_grant = buf_q.v && (!wb_req || hold_q);
    wb_wins  = buf_q.v && !md_grant;

    if (md_grant)    grant = GRANT_MD;
    else if (wb_req) grant = GRANT_WB;
    else             grant = GRANT_IDLE;

    RFWe  = 1'b0;
    A3    = REG_ZERO;
    RF_WD = '0;
    WPC   = '0;
    case (grant)
      GRANT_MD: begin
        RFWe  = 1'b1;
        A3    = buf_q.a3;
        RF_WD = buf_q.wd;
        WPC   = buf_q.pc;
      end
      GRANT_WB: begin
        RFWe  = 1'b1;
        A3    = wb_a3;
        RF_WD = wb_wd;
        WPC   = wb_pc;
      end
      default: ;
    endcase

    buf_d = buf_q;
    if (md_valid && md_ready) begin
      buf_d.v  = 1'b1;
      buf_d.a3 = md_a3;
      buf_d.wd = md_wd;
      buf_d.pc = md_pc;
    end else if (md_grant) begin
      buf_d.v = 1'b0;
    end

    if (!buf_q.v || md_grant) wait_cnt_d = '0;
    else                      wait_cnt_d = wait_cnt_q + CNT_W'(1);

    hold_d = hold_q;
    if (md_grant)                              hold_d = 1'b0;
    else if (wb_wins && wait_cnt_q == WAIT_LAST) hold_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_q      <= '0;
      wait_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
    end
  end

  // WAW stalls in ID guarantee WB and the buffer never race for the same nonzero register.
  rf_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (is_write(md_issue, md_issue_a3)),
    .set_idx (md_issue_a3),
    .clr_en  (md_grant),
    .clr_idx (buf_q.a3),
    .lu_a1   (id_a1),
    .lu_a2   (id_a2),
    .lu_a3   (id_a3),
    .hit_a1  (hit_a1),
    .hit_a2  (hit_a2),
    .hit_a3  (hit_a3)
  );

  assign id_stall = hit_a1 | hit_a2 | hit_a3;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected register-file writes are queued as stimulus
// is driven and popped when the port is sampled; handshake/hazard outputs are checked inline.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } port_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd, wb_pc;
  logic        wb_hold;
  logic        md_valid, md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd, md_pc;
  logic        md_issue;
  logic [4:0]  md_issue_a3;
  logic [4:0]  id_a1, id_a2, id_a3;
  logic        id_stall;
  logic        RFWe;
  logic [4:0]  A3;
  logic [31:0] RF_WD, WPC;

  port_t exp_q[$];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc), .wb_hold(wb_hold),
    .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
    .md_issue(md_issue), .md_issue_a3(md_issue_a3),
    .id_a1(id_a1), .id_a2(id_a2), .id_a3(id_a3), .id_stall(id_stall),
    .RFWe(RFWe), .A3(A3), .RF_WD(RF_WD), .WPC(WPC)
  );

  function automatic port_t mk(input logic we, input logic [4:0] a3,
                               input logic [31:0] wd, input logic [31:0] pc);
    return port_t'({we, a3, wd, pc});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_a3 = 0; wb_wd = 0; wb_pc = 0;
    md_valid = 0; md_a3 = 0; md_wd = 0; md_pc = 0;
    md_issue = 0; md_issue_a3 = 0;
    id_a1 = 0; id_a2 = 0; id_a3 = 0;
  endtask

  task automatic test_reset();
    port_t got, want;
    idle_inputs();
    reset = 0;
    md_valid = 1; md_a3 = 5'd3; md_wd = 32'h3333; md_pc = 32'h30;
    md_issue = 1; md_issue_a3 = 5'd7;
    tick();
    tick();
    reset = 1;
    md_valid = 0; md_issue = 0;
    id_a1 = 5'd7; id_a2 = 5'd3;
    wb_we = 1; wb_a3 = 5'd4; wb_wd = 32'h11; wb_pc = 32'h40;
    exp_q.push_back(mk(1'b1, 5'd4, 32'h11, 32'h40));
    @(negedge clk);
    total++;
    if (md_ready !== 1'b1) $display("[TB] FAIL reset_md_ready: got %b, expected 1", md_ready);
    else passed++;
    total++;
    if (wb_hold !== 1'b0) $display("[TB] FAIL reset_wb_hold: got %b, expected 0", wb_hold);
    else passed++;
    total++;
    if (id_stall !== 1'b0) $display("[TB] FAIL reset_id_stall: got %b, expected 0", id_stall);
    else passed++;
    got = {RFWe, A3, RF_WD, WPC};
    want = exp_q.pop_front();
    total++;
    if (got !== want) $display("[TB] FAIL reset_port: got %h, expected %h", got, want);
    else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_wb_only();
    port_t got, want;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin wb_we = 1; wb_a3 = 5'd8;  wb_wd = 32'h1234;     wb_pc = 32'h100; end
        1: begin wb_we = 1; wb_a3 = 5'd0;  wb_wd = 32'hFFFF;     wb_pc = 32'h104; end
        2: begin wb_we = 1; wb_a3 = 5'd31; wb_wd = 32'hDEADBEEF; wb_pc = 32'h108; end
        default: begin wb_we = 0; wb_a3 = 5'd5; wb_wd = 32'h55; wb_pc = 32'h10C; end
      endcase
      exp_q.push_back((wb_we && wb_a3 != 0) ? mk(1'b1, wb_a3, wb_wd, wb_pc) : mk(1'b0, 5'd0, 32'd0, 32'd0));
      @(negedge clk);
      got = {RFWe, A3, RF_WD, WPC};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("[TB] FAIL wb_only_port[%0d]: got %h, expected %h", i, got, want);
      else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_md_idle();
    port_t got, want;
    logic exp_ready;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) begin
        md_valid = 1; md_a3 = 5'd9; md_wd = 32'hCAFE; md_pc = 32'h200;
      end
      exp_q.push_back((c == 1) ? mk(1'b1, 5'd9, 32'hCAFE, 32'h200) : mk(1'b0, 5'd0, 32'd0, 32'd0));
      exp_ready = (c != 1);
      @(negedge clk);
      total++;
      if (md_ready !== exp_ready) $display("[TB] FAIL md_idle_ready[%0d]: got %b, expected %b", c, md_ready, exp_ready);
      else passed++;
      got = {RFWe, A3, RF_WD, WPC};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("[TB] FAIL md_idle_port[%0d]: got %h, expected %h", c, got, want);
      else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    port_t got, want;
    logic exp_hold, exp_ready;
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 0) begin
        md_valid = 1; md_a3 = 5'd11; md_wd = 32'h5555; md_pc = 32'h300;
        exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 32'd0));
      end else begin
        wb_we = 1; wb_a3 = 5'd12;
        wb_wd = (c >= 5) ? 32'd5 : 32'(c);
        wb_pc = (c >= 5) ? 32'h414 : 32'h400 + 32'(4 * c);
        if (c == 5) exp_q.push_back(mk(1'b1, 5'd11, 32'h5555, 32'h300));
        else        exp_q.push_back(mk(1'b1, 5'd12, wb_wd, wb_pc));
      end
      exp_hold  = (c == 5);
      exp_ready = (c == 0 || c == 6);
      @(negedge clk);
      total++;
      if (wb_hold !== exp_hold) $display("[TB] FAIL starve_hold[%0d]: got %b, expected %b", c, wb_hold, exp_hold);
      else passed++;
      total++;
      if (md_ready !== exp_ready) $display("[TB] FAIL starve_ready[%0d]: got %b, expected %b", c, md_ready, exp_ready);
      else passed++;
      got = {RFWe, A3, RF_WD, WPC};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("[TB] FAIL starve_port[%0d]: got %h, expected %h", c, got, want);
      else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    port_t got, want;
    logic exp_stall;
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      exp_stall = 1'b0;
      case (c)
        0: begin md_issue = 1; md_issue_a3 = 5'd10; end
        1: begin id_a1 = 5'd10; exp_stall = 1; end
        2: begin id_a3 = 5'd10; exp_stall = 1; end
        3: begin id_a2 = 5'd10; exp_stall = 1;
                 md_valid = 1; md_a3 = 5'd10; md_wd = 32'h77; md_pc = 32'h500; end
        4: begin id_a1 = 5'd10; exp_stall = 1; end
        5: begin id_a1 = 5'd10; end
        6: begin md_issue = 1; md_issue_a3 = 5'd0; end
        default: begin id_a1 = 5'd0; id_a2 = 5'd0; id_a3 = 5'd0; end
      endcase
      exp_q.push_back((c == 4) ? mk(1'b1, 5'd10, 32'h77, 32'h500) : mk(1'b0, 5'd0, 32'd0, 32'd0));
      @(negedge clk);
      total++;
      if (id_stall !== exp_stall) $display("[TB] FAIL sb_stall[%0d]: got %b, expected %b", c, id_stall, exp_stall);
      else passed++;
      got = {RFWe, A3, RF_WD, WPC};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("[TB] FAIL sb_port[%0d]: got %h, expected %h", c, got, want);
      else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    port_t got, want;
    logic exp_stall;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      id_a1 = (c == 0) ? 5'd0 : 5'd10;
      exp_stall = (c >= 1 && c <= 4);
      case (c)
        0: begin md_issue = 1; md_issue_a3 = 5'd10; end
        1: begin md_valid = 1; md_a3 = 5'd10; md_wd = 32'hC0; md_pc = 32'h700; end
        2: begin md_issue = 1; md_issue_a3 = 5'd10; end
        3: begin md_valid = 1; md_a3 = 5'd10; md_wd = 32'hC1; md_pc = 32'h704; end
        default: ;
      endcase
      if (c == 2)      exp_q.push_back(mk(1'b1, 5'd10, 32'hC0, 32'h700));
      else if (c == 4) exp_q.push_back(mk(1'b1, 5'd10, 32'hC1, 32'h704));
      else             exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 32'd0));
      @(negedge clk);
      total++;
      if (id_stall !== exp_stall) $display("[TB] FAIL collide_stall[%0d]: got %b, expected %b", c, id_stall, exp_stall);
      else passed++;
      got = {RFWe, A3, RF_WD, WPC};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("[TB] FAIL collide_port[%0d]: got %h, expected %h", c, got, want);
      else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    port_t got, want;
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 0) begin
        md_valid = 1; md_a3 = 5'd13; md_wd = 32'h99; md_pc = 32'h600;
        md_issue = 1; md_issue_a3 = 5'd13;
        exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 32'd0));
      end else begin
        wb_we = 1; wb_a3 = 5'd14; wb_wd = 32'h100 + 32'(c); wb_pc = 32'h800 + 32'(4 * c);
        exp_q.push_back(mk(1'b1, 5'd14, wb_wd, wb_pc));
      end
      @(negedge clk);
      got = {RFWe, A3, RF_WD, WPC};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("[TB] FAIL rstmid_port[%0d]: got %h, expected %h", c, got, want);
      else passed++;
      tick();
    end
    idle_inputs();
    reset = 0;
    md_valid = 1; md_a3 = 5'd2; md_wd = 32'hEE; md_pc = 32'h6EE;
    @(negedge clk);
    total++;
    if (wb_hold !== 1'b1) $display("[TB] FAIL rstmid_pre_hold: got %b, expected 1", wb_hold);
    else passed++;
    total++;
    if (md_ready !== 1'b0) $display("[TB] FAIL rstmid_pre_ready: got %b, expected 0", md_ready);
    else passed++;
    tick();
    idle_inputs();
    reset = 1;
    id_a1 = 5'd13; id_a3 = 5'd2;
    wb_we = 1; wb_a3 = 5'd14; wb_wd = 32'hAB; wb_pc = 32'h900;
    exp_q.push_back(mk(1'b1, 5'd14, 32'hAB, 32'h900));
    @(negedge clk);
    total++;
    if (md_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b, expected 1", md_ready);
    else passed++;
    total++;
    if (wb_hold !== 1'b0) $display("[TB] FAIL rstmid_hold: got %b, expected 0", wb_hold);
    else passed++;
    total++;
    if (id_stall !== 1'b0) $display("[TB] FAIL rstmid_stall: got %b, expected 0", id_stall);
    else passed++;
    got = {RFWe, A3, RF_WD, WPC};
    want = exp_q.pop_front();
    total++;
    if (got !== want) $display("[TB] FAIL rstmid_port_wb: got %h, expected %h", got, want);
    else passed++;
    tick();
    idle_inputs();
    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 32'd0));
    @(negedge clk);
    got = {RFWe, A3, RF_WD, WPC};
    want = exp_q.pop_front();
    total++;
    if (got !== want) $display("[TB] FAIL rstmid_port_idle: got %h, expected %h", got, want);
    else passed++;
    total++;
    if (md_ready !== 1'b1) $display("[TB] FAIL rstmid_ready_idle: got %b, expected 1", md_ready);
    else passed++;
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_wb_only();
    test_md_idle();
    test_starvation();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
